// File: rtl/score_reader.sv
// Score RAM scanner: finds max/argmax (and the running total when SCORE_READER_TOTAL_EN
// is defined), then lets the user browse entries one read at a time.
module score_reader (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [5:0]  i_entry_count,
  input  logic [7:0]  i_ram_q,
  input  logic        i_step,
  output logic [4:0]  o_ram_address,
  output logic        o_ram_rden,
  output logic        o_busy,
  output logic        o_scan_done,
  output logic [7:0]  o_high_score,
  output logic [4:0]  o_high_index,
  output logic [12:0] o_total_score,
  output logic [7:0]  o_disp_score,
  output logic [4:0]  o_disp_index,
  output logic        o_disp_valid
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_BROWSE, S_FETCH} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_n;
  logic [4:0]  r_cnt;
  logic [4:0]  r_addr_hold;
  logic        r_cap_vld_p1;
  logic [4:0]  r_cap_idx_p1;
  logic        r_scan_done;
  logic [7:0]  r_high_score;
  logic [4:0]  r_high_index;
  logic [7:0]  r_disp_score;
  logic [4:0]  r_disp_index;
  logic        r_disp_valid;

  logic [5:0]  w_n_clamp;
  logic        w_start_ok;
  logic [4:0]  w_next_idx;
  logic        w_rden;
  logic [4:0]  w_addr;

  assign w_n_clamp  = (i_entry_count > 6'd32) ? 6'd32 : i_entry_count;
  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_BROWSE);
  assign w_next_idx = (({1'b0, r_disp_index} + 6'd1) == r_n) ? 5'd0 : r_disp_index + 5'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Browse reads are issued combinationally in the step cycle so the display updates two cycles later
  always_comb begin
    w_next = r_state;
    w_rden = 1'b0;
    w_addr = r_addr_hold;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (w_n_clamp == 6'd0) ? S_IDLE : S_SCAN;
      end
      S_SCAN: begin
        w_rden = 1'b1;
        w_addr = r_cnt;
        if ({1'b0, r_cnt} == r_n - 6'd1) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_BROWSE;
      S_BROWSE: begin
        if (i_start) begin
          w_next = (w_n_clamp == 6'd0) ? S_IDLE : S_SCAN;
        end else if (i_step) begin
          w_rden = 1'b1;
          w_addr = w_next_idx;
          w_next = S_FETCH;
        end
      end
      S_FETCH: w_next = S_BROWSE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n          <= '0;
      r_cnt        <= '0;
      r_addr_hold  <= '0;
      r_cap_vld_p1 <= 1'b0;
      r_cap_idx_p1 <= '0;
      r_scan_done  <= 1'b0;
      r_high_score <= '0;
      r_high_index <= '0;
      r_disp_score <= '0;
      r_disp_index <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      r_scan_done  <= (w_start_ok && w_n_clamp == 6'd0) || (r_state == S_DRAIN);
      if (w_rden) r_addr_hold <= w_addr;
      // p1: RAM data for the address issued last cycle
      r_cap_vld_p1 <= (r_state == S_SCAN);
      r_cap_idx_p1 <= r_cnt;
      if (w_start_ok) begin
        r_n          <= w_n_clamp;
        r_cnt        <= '0;
        r_high_score <= '0;
        r_high_index <= '0;
        r_disp_valid <= 1'b0;
      end else begin
        if (r_state == S_SCAN) r_cnt <= r_cnt + 5'd1;
        if (r_cap_vld_p1) begin
          if (i_ram_q > r_high_score) begin
            r_high_score <= i_ram_q;
            r_high_index <= r_cap_idx_p1;
          end
          if (r_cap_idx_p1 == 5'd0) r_disp_score <= i_ram_q;
        end
        if (r_state == S_DRAIN) begin
          r_disp_index <= '0;
          r_disp_valid <= 1'b1;
        end
        if (r_state == S_FETCH) begin
          r_disp_score <= i_ram_q;
          r_disp_index <= r_addr_hold;
        end
      end
    end
  end

`ifdef SCORE_READER_TOTAL_EN
  logic [12:0] r_total;

  always_ff @(posedge i_clk) begin
    if (i_rst)             r_total <= '0;
    else if (w_start_ok)   r_total <= '0;
    else if (r_cap_vld_p1) r_total <= r_total + {5'd0, i_ram_q};
  end

  assign o_total_score = r_total;
`else
  assign o_total_score = '0;
`endif

  assign o_ram_address = w_addr;
  assign o_ram_rden    = w_rden;
  assign o_busy        = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign o_scan_done   = r_scan_done;
  assign o_high_score  = r_high_score;
  assign o_high_index  = r_high_index;
  assign o_disp_score  = r_disp_score;
  assign o_disp_index  = r_disp_index;
  assign o_disp_valid  = r_disp_valid;

endmodule

// File: doc/score_reader.md
SCORE_READER -- requirements
Module: score_reader

Interface
REQ-001 clk  input  1  rising-edge clock; the only clock in the block.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse that begins a scan of the score RAM.
REQ-004 entry_count  input  6  number of valid score entries written, 0..32; values above 32 are treated as 32.
REQ-005 ram_q  input  8  score RAM read data, valid one cycle after ram_address and ram_rden are presented.
REQ-006 ram_address  output  5  score RAM read address.
REQ-007 ram_rden  output  1  score RAM read enable; the block never drives a write enable.
REQ-008 step  input  1  one-cycle pulse that advances the browse display to the next entry.
REQ-009 busy  output  1  high in SCAN and DRAIN.
REQ-010 scan_done  output  1  one-cycle pulse when scan results are final.
REQ-011 high_score  output  8  maximum score found.
REQ-012 high_index  output  5  address of that maximum score.
REQ-013 total_score  output  13  sum of all scanned scores.
REQ-014 disp_score  output  8  score of the currently browsed entry.
REQ-015 disp_index  output  5  address of the currently browsed entry.
REQ-016 disp_valid  output  1  disp_score and disp_index are meaningful.

Function
REQ-017 The FSM SHALL have the states IDLE, SCAN, DRAIN, BROWSE and FETCH.
REQ-018 In IDLE, a start pulse SHALL clear high_score, high_index, total_score and disp_valid, and SHALL move the FSM to SCAN, or to IDLE with scan_done asserted on the next cycle when the clamped count N is 0.
REQ-019 In SCAN, ram_rden SHALL be asserted every cycle with ram_address stepping 0..N-1, one address per cycle; after address N-1 is issued, the FSM SHALL move to DRAIN.
REQ-020 Each ram_q SHALL be captured exactly one cycle after its address is issued; DRAIN SHALL last one cycle, to capture the final word.
REQ-021 On capture, if ram_q is strictly greater than high_score, the block SHALL load high_score and high_index; ties SHALL keep the lowest index.
REQ-022 On leaving DRAIN, the block SHALL pulse scan_done for one cycle, set disp_score and disp_index to entry 0, set disp_valid to 1 and enter BROWSE. Scan latency from start to scan_done is N+2 cycles.
REQ-023 In BROWSE, a step pulse SHALL issue a read of (disp_index+1) and enter FETCH; the index SHALL wrap from N-1 to 0.
REQ-024 FETCH SHALL last one cycle, then load disp_score and disp_index and return to BROWSE; disp updates 2 cycles after step.
REQ-025 A step pulse SHALL be ignored in IDLE, SCAN, DRAIN and FETCH.
REQ-026 A start pulse SHALL be ignored in SCAN, DRAIN and FETCH; in BROWSE it SHALL restart per REQ-018.
REQ-027 If start and step occur in the same BROWSE cycle, start SHALL win.
REQ-028 When not reading, ram_rden SHALL be 0 and ram_address SHALL hold its value.
REQ-029 high_score and total_score SHALL hold their values from scan_done until the next start.

Reset
REQ-030 Reset SHALL put the FSM in IDLE and set every output to 0, including ram_address and ram_rden.
REQ-031 Reset SHALL take priority over start and step.
REQ-032 Reset asserted mid-scan SHALL abort the scan with no scan_done pulse.

Configuration
REQ-033 With SCORE_READER_TOTAL_EN defined, total_score SHALL accumulate each captured ram_q without saturation; the 13-bit width covers the maximum sum of 32x255 = 8160.
REQ-034 Without SCORE_READER_TOTAL_EN, total_score SHALL be constant 0 and no accumulator is built; all other behaviour is identical.

Verification
REQ-035 Scenario 1: RAM[0..3] = 5, 9, 2, 9; entry_count = 4; start -> scan_done 6 cycles later; high_score = 9, high_index = 1, total_score = 25 (with the macro).
REQ-036 Scenario 2: entry_count = 0; start -> scan_done next cycle; all results 0; disp_valid = 0; no ram_rden pulse.
REQ-037 Scenario 3: entry_count = 40 with all 32 entries at 255 -> exactly 32 reads; total_score = 8160; high_index = 0.
REQ-038 Scenario 4: after Scenario 1, four step pulses spaced 3 cycles apart -> disp_index 1, 2, 3, 0 and disp_score 9, 2, 9, 5.
REQ-039 Scenario 5: Reset during cycle 2 of SCAN -> all outputs 0 the next cycle; no scan_done; a following start rescans correctly.
REQ-040 Scenario 6: start and step in the same BROWSE cycle -> rescan begins; disp_valid = 0 until the new scan_done.
